lane_hit_arbiter: RTL and testbench

//  Sits between raw F1~F4 lane keys and the single hit-judge/score port of the block manager.
//  Per lane: synchronises, debounces and edge-detects the key, then queues one pending hit with a tick timestamp.

---
 rtl/lane_hit_arbiter.sv | 158 +++++++++++++++
 tb/tb_lane_hit_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_hit_arbiter.sv
// Four-lane key front end: sync, debounce and press detection per lane, a single-slot
// pending hit per lane with its tick stamp, and a round-robin valid/ready request port.
module lane_hit_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19,
    parameter int unsigned TICK_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        key_n,
    input  logic              enable,
    input  logic [TICK_W-1:0] tick_count,
    output logic              req_valid,
    output logic [1:0]        req_lane,
    output logic [TICK_W-1:0] req_tick,
    input  logic              req_ready,
    output logic              drop_pulse,
    output logic [7:0]        drop_count
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]        sync1;
    logic [3:0]        sync2;
    logic [3:0]        stable;
    logic [3:0]        stable_q;
    logic [CNT_W-1:0]  cnt [4];
    logic [3:0]        press;

    logic [3:0]        pending;
    logic [3:0]        pending_n;
    logic [TICK_W-1:0] tick_q [4];
    logic [3:0]        tick_load;
    logic [3:0]        drop_vec;
    logic [2:0]        drop_inc;
    logic [8:0]        drop_sum;

    state_t            state;
    logic [1:0]        rr_ptr;
    logic              handshake;
    logic [3:0]        grant_mask;
    logic              pick_found;
    logic [1:0]        pick_lane;
    logic [1:0]        idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '1;
            sync2    <= '1;
            stable   <= '1;
            stable_q <= '1;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1    <= key_n;
            sync2    <= sync1;
            stable_q <= stable;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Falling edge of the debounced level only; releases never generate events.
    assign press      = stable_q & ~stable;
    assign handshake  = req_valid & req_ready;
    assign grant_mask = (state == GRANT) ? (4'b0001 << req_lane) : 4'b0000;

    // A lane's own handshake frees the slot in the same cycle, so a coincident press is taken, not dropped.
    always_comb begin
        pending_n = '0;
        tick_load = '0;
        drop_vec  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            logic set_i;
            logic clr_i;
            logic keep_i;
            set_i  = press[i] & enable;
            clr_i  = handshake & (req_lane == 2'(i));
            keep_i = pending[i] & ~clr_i & (enable | grant_mask[i]);
            pending_n[i] = set_i | keep_i;
            tick_load[i] = set_i & (~pending[i] | clr_i);
            drop_vec[i]  = set_i & pending[i] & ~clr_i;
        end
        drop_inc = 3'(drop_vec[0]) + 3'(drop_vec[1]) + 3'(drop_vec[2]) + 3'(drop_vec[3]);
        drop_sum = {1'b0, drop_count} + 9'(drop_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
            for (int unsigned i = 0; i < 4; i++) tick_q[i] <= '0;
        end else begin
            pending    <= pending_n;
            drop_pulse <= |drop_vec;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            for (int unsigned i = 0; i < 4; i++) begin
                if (tick_load[i]) tick_q[i] <= tick_count;
            end
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_lane  = rr_ptr;
        idx        = rr_ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!pick_found && pending[idx]) begin
                pick_found = 1'b1;
                pick_lane  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            req_valid <= 1'b0;
            req_lane  <= '0;
            req_tick  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && pick_found) begin
                        req_valid <= 1'b1;
                        req_lane  <= pick_lane;
                        req_tick  <= tick_q[pick_lane];
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        rr_ptr    <= req_lane + 2'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_hit_arbiter.sv
// Directed bench for lane_hit_arbiter with a 4-cycle debounce window.
module tb_lane_hit_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_n;
    logic       enable;
    logic [7:0] tick_count;
    logic       req_valid;
    logic [1:0] req_lane;
    logic [7:0] req_tick;
    logic       req_ready;
    logic       drop_pulse;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;

    lane_hit_arbiter #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .TICK_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_n(key_n),
        .enable(enable),
        .tick_count(tick_count),
        .req_valid(req_valid),
        .req_lane(req_lane),
        .req_tick(req_tick),
        .req_ready(req_ready),
        .drop_pulse(drop_pulse),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_n = 4'hF; enable = 1'b0; tick_count = 8'h00; req_ready = 1'b0;
        #22;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", req_valid); end
        checks++; if (req_lane !== 2'd0) begin failures++; $display("FAIL rst_lane got=%0h exp=0", req_lane); end
        checks++; if (req_tick !== 8'h00) begin failures++; $display("FAIL rst_tick got=%0h exp=0", req_tick); end
        checks++; if (drop_pulse !== 1'b0 || drop_count !== 8'h00) begin failures++; $display("FAIL rst_drop got=%0h/%0h exp=0/0", drop_pulse, drop_count); end
        checks++; if (dut.pending !== 4'h0 || dut.rr_ptr !== 2'd0) begin failures++; $display("FAIL rst_state got=%0h/%0h exp=0/0", dut.pending, dut.rr_ptr); end
        checks++; if (dut.stable !== 4'hF) begin failures++; $display("FAIL rst_stable got=%0h exp=f", dut.stable); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_press();
        int nv = 0; int first = 0; logic [1:0] lane = '0; logic [7:0] tk = '0;
        enable = 1'b1; tick_count = 8'h2A; req_ready = 1'b1; key_n = 4'b1110;
        for (int s = 1; s <= 30; s++) begin
            step();
            if (req_valid === 1'b1) begin
                nv++;
                if (first == 0) begin first = s; lane = req_lane; tk = req_tick; end
            end
            if (s == 8) key_n = 4'b1111;
        end
        checks++; if (nv != 1) begin failures++; $display("FAIL single_valid_cycles got=%0d exp=1", nv); end
        checks++; if (first != 8) begin failures++; $display("FAIL single_latency got=%0d exp=8", first); end
        checks++; if (lane !== 2'd0 || tk !== 8'h2A) begin failures++; $display("FAIL single_lane_tick got=%0h/%0h exp=0/2a", lane, tk); end
        checks++; if (dut.rr_ptr !== 2'd1) begin failures++; $display("FAIL single_rr got=%0h exp=1", dut.rr_ptr); end
    endtask

    task automatic test_glitch();
        int nv = 0;
        key_n = 4'b1110;
        for (int s = 1; s <= 25; s++) begin
            step();
            if (req_valid === 1'b1) nv++;
            if (s == 3) key_n = 4'b1111;
        end
        checks++; if (nv != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", nv); end
        checks++; if (drop_count !== 8'h00 || dut.pending !== 4'h0) begin failures++; $display("FAIL glitch_state got=%0h/%0h exp=0/0", drop_count, dut.pending); end
    endtask

    task automatic test_round_robin();
        int nv = 0; int vstep [8]; logic [1:0] vlane [8]; logic [7:0] vtick [8];
        reset_dut();
        enable = 1'b1; tick_count = 8'h3C; req_ready = 1'b1; key_n = 4'b0000;
        for (int s = 1; s <= 30; s++) begin
            step();
            if (req_valid === 1'b1 && nv < 8) begin
                vstep[nv] = s; vlane[nv] = req_lane; vtick[nv] = req_tick; nv++;
            end
            if (s == 8) key_n = 4'b1111;
        end
        checks++; if (nv != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", nv); end
        for (int i = 0; i < 4 && i < nv; i++) begin
            checks++;
            if (vlane[i] !== 2'(i) || vstep[i] != 8 + 2 * i || vtick[i] !== 8'h3C) begin
                failures++;
                $display("FAIL rr_grant%0d got lane=%0h step=%0d tick=%0h exp lane=%0h step=%0d tick=3c",
                         i, vlane[i], vstep[i], vtick[i], i, 8 + 2 * i);
            end
        end
        checks++; if (dut.rr_ptr !== 2'd0 || dut.pending !== 4'h0) begin failures++; $display("FAIL rr_end got=%0h/%0h exp=0/0", dut.rr_ptr, dut.pending); end
    endtask

    task automatic test_drop_in_grant();
        int first = 0; int bad = 0; int npulse = 0; int nv = 0;
        req_ready = 1'b0; tick_count = 8'h55; key_n = 4'b1011;
        for (int s = 1; s <= 40; s++) begin
            step();
            if (req_valid === 1'b1 && first == 0) first = s;
            if (s >= 8 && (req_valid !== 1'b1 || req_lane !== 2'd2 || req_tick !== 8'h55)) bad++;
            if (drop_pulse === 1'b1) npulse++;
            if (s == 8) key_n = 4'b1111;
            if (s == 20) begin tick_count = 8'h77; key_n = 4'b1011; end
            if (s == 28) key_n = 4'b1111;
        end
        checks++; if (first != 8) begin failures++; $display("FAIL hold_latency got=%0d exp=8", first); end
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable got=%0d exp=0", bad); end
        checks++; if (npulse != 1) begin failures++; $display("FAIL drop_pulse_cycles got=%0d exp=1", npulse); end
        checks++; if (drop_count !== 8'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", drop_count); end
        checks++; if (dut.tick_q[2] !== 8'h55) begin failures++; $display("FAIL drop_tick_kept got=%0h exp=55", dut.tick_q[2]); end
        req_ready = 1'b1;
        step();
        checks++; if (req_valid !== 1'b0 || dut.pending !== 4'h0 || dut.rr_ptr !== 2'd3) begin failures++; $display("FAIL hold_release got=%0h/%0h/%0h exp=0/0/3", req_valid, dut.pending, dut.rr_ptr); end
        for (int s = 1; s <= 10; s++) begin step(); if (req_valid === 1'b1) nv++; end
        checks++; if (nv != 0) begin failures++; $display("FAIL hold_no_repeat got=%0d exp=0", nv); end
    endtask

    task automatic test_enable_fall();
        int nv = 0;
        reset_dut();
        enable = 1'b1; req_ready = 1'b0; tick_count = 8'h11; key_n = 4'b0101;
        for (int s = 1; s <= 12; s++) begin
            step();
            if (s == 8) key_n = 4'b1111;
        end
        checks++; if (req_valid !== 1'b1 || req_lane !== 2'd1 || dut.pending !== 4'b1010) begin failures++; $display("FAIL en_pre got=%0h/%0h/%0h exp=1/1/a", req_valid, req_lane, dut.pending); end
        enable = 1'b0;
        step(); step();
        checks++; if (dut.pending !== 4'b0010 || req_valid !== 1'b1 || req_lane !== 2'd1 || req_tick !== 8'h11) begin failures++; $display("FAIL en_fall got=%0h/%0h/%0h/%0h exp=2/1/1/11", dut.pending, req_valid, req_lane, req_tick); end
        req_ready = 1'b1;
        step();
        checks++; if (req_valid !== 1'b0 || dut.pending !== 4'h0 || dut.rr_ptr !== 2'd2) begin failures++; $display("FAIL en_complete got=%0h/%0h/%0h exp=0/0/2", req_valid, dut.pending, dut.rr_ptr); end
        enable = 1'b1;
        for (int s = 1; s <= 15; s++) begin step(); if (req_valid === 1'b1) nv++; end
        checks++; if (nv != 0 || drop_count !== 8'd0) begin failures++; $display("FAIL en_lane3_lost got=%0d/%0d exp=0/0", nv, drop_count); end
    endtask

    task automatic test_drop_saturate();
        req_ready = 1'b0; enable = 1'b1; key_n = 4'b1110;
        for (int s = 1; s <= 16; s++) begin
            step();
            if (s == 8) key_n = 4'b1111;
        end
        checks++; if (req_valid !== 1'b1 || req_lane !== 2'd0) begin failures++; $display("FAIL sat_grant got=%0h/%0h exp=1/0", req_valid, req_lane); end
        for (int n = 1; n <= 300; n++) begin
            key_n = 4'b1110;
            for (int s = 0; s < 6; s++) step();
            key_n = 4'b1111;
            for (int s = 0; s < 6; s++) step();
            if (n == 10) begin
                checks++; if (drop_count !== 8'd10) begin failures++; $display("FAIL sat_mid got=%0d exp=10", drop_count); end
            end
        end
        for (int s = 0; s < 4; s++) step();
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d exp=255", drop_count); end
        checks++; if (req_valid !== 1'b1 || req_lane !== 2'd0) begin failures++; $display("FAIL sat_hold got=%0h/%0h exp=1/0", req_valid, req_lane); end
    endtask

    task automatic test_reset_in_grant();
        checks++; if (req_valid !== 1'b1 || dut.rr_ptr !== 2'd2) begin failures++; $display("FAIL rig_pre got=%0h/%0h exp=1/2", req_valid, dut.rr_ptr); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rig_valid got=%0h exp=0", req_valid); end
        checks++; if (dut.pending !== 4'h0 || dut.rr_ptr !== 2'd0 || drop_count !== 8'd0) begin failures++; $display("FAIL rig_state got=%0h/%0h/%0d exp=0/0/0", dut.pending, dut.rr_ptr, drop_count); end
        #10;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_round_robin();
        test_drop_in_grant();
        test_enable_fall();
        test_drop_saturate();
        test_reset_in_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
